mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised successor to the team's fixed 2-bit free-running counter.
- Configurable width and modulus; up/down direction; count enable; synchronous parallel load.
- Wrap or saturate at the limits; output in binary or Gray code; terminal-count pulse and sticky overflow flag.
- Used as a general event/sequence counter wherever a small fixed counter was previously instantiated.

Parameters:
- WIDTH, 2, counter and output width in bits (legal range 1..16).
- MAX_COUNT, 2**WIDTH-1, highest count value; count range is 0..MAX_COUNT; must be <= 2**WIDTH-1.
- WRAP, 1, 1 = wrap at the limits (MAX_COUNT->0 up, 0->MAX_COUNT down); 0 = saturate at the limits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- gray_mode  input  1  output encoding: 0 = binary, 1 = Gray.
- clr_ovf  input  1  clears the sticky overflow flag.
- q  output  WIDTH  count value in the selected encoding.
- tc  output  1  terminal-count indicator.
- ovf  output  1  sticky wrap/saturation-hit flag.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, RESET. Polarity and synchronicity are fixed.
- State: internal binary register cnt[WIDTH-1:0] and flag register ovf_r.
- Reset: when RESET=1 at a rising edge, cnt<=0 and ovf_r<=0. Outputs then read q=0 (0 in both encodings), tc=0 unless en=1 and up=0, ovf=0. RESET overrides all other inputs, including mid-count and mid-load.
- Update priority each edge (after RESET):
  - load: cnt <= min(load_val, MAX_COUNT). Out-of-range loads clamp to MAX_COUNT. ovf_r is cleared.
  - else en with up=1:
    - cnt<MAX_COUNT: cnt+1.
    - cnt==MAX_COUNT: becomes 0 if WRAP=1, holds if WRAP=0; ovf_r<=1 in both cases.
  - else en with up=0:
    - cnt>0: cnt-1.
    - cnt==0: becomes MAX_COUNT if WRAP=1, holds if WRAP=0; ovf_r<=1 in both cases.
  - else hold.
- clr_ovf: clears ovf_r on the edge unless the same edge sets it. Set wins over clear.
- Latency: cnt changes one edge after en/load sampled. q, tc and ovf are combinational from registers and current inputs; no extra pipeline stage.
- q = cnt when gray_mode=0; q = cnt ^ (cnt>>1) when gray_mode=1. gray_mode may change at any time and affects q immediately; cnt is unaffected.
- tc = en & ~load & ((up & cnt==MAX_COUNT) | (~up & cnt==0)). It is high exactly in the cycle whose edge wraps or saturates.
- ovf = ovf_r.
- Direction change mid-count is legal and takes effect on the next enabled edge.
- Arithmetic: unsigned, WIDTH bits. The compare to MAX_COUNT uses the WIDTH-bit constant. No X propagation from load_val when load=0.

Decomposition:
- Shared package counter_pkg:
  - localparam encoding constants ENC_BIN=1'b0, ENC_GRAY=1'b1.
  - function bin2gray(parameterised by WIDTH via wrapper).
  - function clamp for the load path.
- One natural sub-module: bin2gray_enc (WIDTH-parametrised combinational encoder), instantiated on the output path. Keeps the counter core encoding-agnostic and reusable by future Gray-coded pointers.

Test Plan:
Benches run WIDTH=4, MAX_COUNT=9 unless stated otherwise.
1. Reset then count up, WRAP=1: RESET=1 for 1 edge, then en=1, up=1, 12 edges.
   - q: 0,1,…,9,0,1.
   - tc high only while cnt=9.
   - ovf rises after the 9->0 edge.
2. Down-count saturate, WRAP=0: load load_val=2, then en=1, up=0, 4 edges.
   - q: 2,1,0,0,0.
   - tc high while cnt=0.
   - ovf=1 after the first edge at 0.
3. Load clamp and priority: load=1, load_val=4'hE, en=1 in the same cycle.
   - cnt=9 next cycle (not incremented).
   - ovf cleared.
   - tc=0 in the load cycle.
4. Gray output: load 5, gray_mode=1 → q=4'b0111. Load 9 → q=4'b1101. Toggle gray_mode=0 with no edge → q=4'b1001 immediately.
5. Mid-operation reset and clr_ovf race:
   - Force ovf=1, then assert clr_ovf on a wrap edge → ovf stays 1.
   - Next edge with clr_ovf only → ovf=0.
   - RESET during en=1 at cnt=7 → cnt=0 next edge.
6. Default parameters (WIDTH=2, MAX_COUNT=3, WRAP=1): en=1, up=1 free run → q sequence 0,1,2,3,0 with period 4 clk cycles (40 ns at 10 ns clk).

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encoding constants and helpers for the counter family.
// Helpers work on MAX_W-bit values; callers zero-extend and truncate to their own width.
package counter_pkg;

    localparam logic ENC_BIN  = 1'b0;
    localparam logic ENC_GRAY = 1'b1;
    localparam int   MAX_W    = 16;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] clamp(input logic [MAX_W-1:0] val,
                                               input logic [MAX_W-1:0] limit);
        return (val > limit) ? limit : val;
    endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// WIDTH-parametrised combinational binary-to-Gray encoder.
// Kept separate so Gray-coded pointers elsewhere can reuse it.
module bin2gray_enc
    import counter_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = WIDTH'(bin2gray(MAX_W'(bin_i)));

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate limits, Gray output,
// terminal-count indication and a sticky overflow flag.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter bit WRAP      = 1'b1
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             gray_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_zero, limit_hit;
    logic [WIDTH-1:0] gray_val;

    assign at_max  = (cnt_q == MAX_C);
    assign at_zero = (cnt_q == '0);

    always_comb begin
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        limit_hit = 1'b0;
        if (load) begin
            cnt_d = WIDTH'(clamp(MAX_W'(load_val), MAX_W'(MAX_C)));
            ovf_d = 1'b0;
        end else begin
            if (en && up) begin
                if (at_max) begin
                    cnt_d     = WRAP ? '0 : cnt_q;
                    limit_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else if (en) begin
                if (at_zero) begin
                    cnt_d     = WRAP ? MAX_C : cnt_q;
                    limit_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            // A limit hit on the same edge as clr_ovf keeps the flag set.
            if (limit_hit) begin
                ovf_d = 1'b1;
            end else if (clr_ovf) begin
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    bin2gray_enc #(.WIDTH(WIDTH)) u_enc (
        .bin_i  (cnt_q),
        .gray_o (gray_val)
    );

    assign q   = (gray_mode == ENC_GRAY) ? gray_val : cnt_q;
    assign tc  = en & ~load & ((up & at_max) | (~up & at_zero));
    assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: wrap, saturate and default-parameter instances
// driven in lockstep and compared against an integer reference model.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, gray_mode, clr_ovf;
    logic [3:0] load_val;

    logic [3:0] q_w, q_s;
    logic [1:0] q_d;
    logic       tc_w, tc_s, tc_d, ovf_w, ovf_s, ovf_d;

    int checks = 0;
    int errors = 0;

    // model state per instance: 0 = wrap (4,9), 1 = saturate (4,9), 2 = defaults (2,3)
    int m_cnt[3];
    int m_ovf[3];
    int m_max[3]  = '{9, 9, 3};
    int m_wrap[3] = '{1, 0, 1};
    int m_w[3]    = '{4, 4, 2};

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .RESET(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .gray_mode(gray_mode), .clr_ovf(clr_ovf), .q(q_w), .tc(tc_w), .ovf(ovf_w)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1'b0)) dut_sat (
        .clk(clk), .RESET(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .gray_mode(gray_mode), .clr_ovf(clr_ovf), .q(q_s), .tc(tc_s), .ovf(ovf_s)
    );

    mod_updown_counter dut_def (
        .clk(clk), .RESET(rst), .en(en), .up(up), .load(load), .load_val(load_val[1:0]),
        .gray_mode(gray_mode), .clr_ovf(clr_ovf), .q(q_d), .tc(tc_d), .ovf(ovf_d)
    );

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            int lv;
            bit hit;
            lv  = int'(load_val) % (1 << m_w[i]);
            hit = 1'b0;
            if (rst) begin
                m_cnt[i] = 0;
                m_ovf[i] = 0;
            end else if (load) begin
                m_cnt[i] = (lv > m_max[i]) ? m_max[i] : lv;
                m_ovf[i] = 0;
            end else begin
                if (en && up) begin
                    if (m_cnt[i] == m_max[i]) begin
                        hit = 1'b1;
                        if (m_wrap[i] == 1) m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else if (en) begin
                    if (m_cnt[i] == 0) begin
                        hit = 1'b1;
                        if (m_wrap[i] == 1) m_cnt[i] = m_max[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
                if (hit) m_ovf[i] = 1;
                else if (clr_ovf) m_ovf[i] = 0;
            end
        end
    endtask

    task automatic check_dut(input string tag, input int i, input logic [15:0] q_obs,
                             input logic tc_obs, input logic ovf_obs);
        logic [15:0] q_exp;
        logic        tc_exp, ovf_exp;
        q_exp   = gray_mode ? 16'(m_cnt[i] ^ (m_cnt[i] >> 1)) : 16'(m_cnt[i]);
        tc_exp  = en && !load && ((up && m_cnt[i] == m_max[i]) || (!up && m_cnt[i] == 0));
        ovf_exp = (m_ovf[i] != 0);
        checks++;
        assert (q_obs === q_exp) else begin
            errors++;
            $error("[TB] FAIL %s.q observed %0h expected %0h", tag, q_obs, q_exp);
        end
        checks++;
        assert (tc_obs === tc_exp) else begin
            errors++;
            $error("[TB] FAIL %s.tc observed %b expected %b", tag, tc_obs, tc_exp);
        end
        checks++;
        assert (ovf_obs === ovf_exp) else begin
            errors++;
            $error("[TB] FAIL %s.ovf observed %b expected %b", tag, ovf_obs, ovf_exp);
        end
    endtask

    task automatic check_output();
        check_dut("wrap", 0, {12'b0, q_w}, tc_w, ovf_w);
        check_dut("sat",  1, {12'b0, q_s}, tc_s, ovf_s);
        check_dut("def",  2, {14'b0, q_d}, tc_d, ovf_d);
    endtask

    // Drive one cycle: inputs at negedge, check combinational outputs, then clock.
    task automatic apply_stimulus(input logic r, input logic e, input logic u, input logic l,
                                  input logic [3:0] lv, input logic g, input logic c);
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_val = lv; gray_mode = g; clr_ovf = c;
        #1 check_output();
        @(posedge clk);
        model_update();
    endtask

    task automatic check_const(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'h0;
        gray_mode = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 0;
        end

        // reset, then count up through the wrap
        apply_stimulus(1, 0, 1, 0, 4'h0, 0, 0);
        for (int k = 0; k < 12; k++) apply_stimulus(0, 1, 1, 0, 4'h0, 0, 0);

        // load 2 then count down into the lower limit
        apply_stimulus(0, 0, 0, 1, 4'h2, 0, 0);
        for (int k = 0; k < 4; k++) apply_stimulus(0, 1, 0, 0, 4'h0, 0, 0);

        // out-of-range load with en high: clamp, no increment
        apply_stimulus(0, 1, 1, 1, 4'hE, 0, 0);
        apply_stimulus(0, 0, 1, 0, 4'h0, 0, 0);

        // Gray output values and immediate encoding switch
        apply_stimulus(0, 0, 1, 1, 4'h5, 1, 0);
        @(negedge clk);
        #1 check_const("gray5", q_w, 4'b0111);
        apply_stimulus(0, 0, 1, 1, 4'h9, 1, 0);
        @(negedge clk);
        #1 check_const("gray9", q_w, 4'b1101);
        gray_mode = 1'b0;
        #1 check_const("bin9", q_w, 4'b1001);
        check_output();

        // wrap sets ovf, then a second wrap with clr_ovf keeps it set
        apply_stimulus(0, 1, 1, 0, 4'h0, 0, 0);
        for (int k = 0; k < 9; k++) apply_stimulus(0, 1, 1, 0, 4'h0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 4'h0, 0, 1);
        apply_stimulus(0, 0, 1, 0, 4'h0, 0, 1);
        apply_stimulus(0, 0, 1, 0, 4'h0, 0, 0);

        // reset while counting from 7
        apply_stimulus(0, 0, 1, 1, 4'h7, 0, 0);
        apply_stimulus(1, 1, 1, 0, 4'h0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 4'h0, 0, 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            apply_stimulus(($urandom_range(31) == 0), ($urandom_range(3) != 0),
                           1'($urandom), ($urandom_range(7) == 0), 4'($urandom),
                           1'($urandom), ($urandom_range(7) == 0));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
